lz77_stream_encoder: RTL
========================

Name: lz77_stream_encoder

Overview:
- Streaming, parametrised LZ77 encoder. Accepts characters over a valid/ready input handshake, with no whole-string preload and no fixed string length.
- Emits (offset, match_len, char_nxt) tokens over a valid/ready output handshake.
- Search-buffer depth, look-ahead depth and char width are parameters.
- Sits between the character source and the token packer. The stream terminates on END_CHAR.

Parameters:
- CHAR_W, 8, bits per character.
- SEARCH_LEN, 9, search-buffer depth in chars (>=2).
- LOOK_LEN, 8, look-ahead depth in chars (>=2).
- OFF_W, 4, offset width; must satisfy 2**OFF_W >= SEARCH_LEN.
- LEN_W, 3, match_len width; must satisfy 2**LEN_W >= LOOK_LEN.
- END_CHAR, 8'h24, terminator character ('$').

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  encoder accepts in_data this cycle.
- in_data  in  CHAR_W  input character.
- out_valid  out  1  token valid.
- out_ready  in  1  consumer accepts the token.
- offset  out  OFF_W  match distance minus 1 (0 = char immediately before look-ahead).
- match_len  out  LEN_W  matched char count.
- char_nxt  out  CHAR_W  literal following the match.
- finish  out  1  high after the END_CHAR token is accepted.

Behaviour:
- Reset (sync, active-high, wins over all): all outputs 0; window entries marked invalid; ended=0; state SHIFT with pend=LOOK_LEN. A reset mid-stream discards all state.
- Window: shift register of SEARCH_LEN+LOOK_LEN entries, each carrying a valid bit. Search entries S[1..SEARCH_LEN] sit at distance d before the look-ahead. Look-ahead entries are L[0..LOOK_LEN-1]. la_cnt = number of valid look-ahead entries.
- SHIFT state, with pend = chars still to shift:
  - in_ready = !ended.
  - If in_valid&&in_ready: shift once, insert in_data at the tail, pend-1. Set ended if in_data==END_CHAR.
  - Else if ended: shift once, insert an invalid entry, pend-1.
  - Else: stall (no shift).
  - pend==0 -> MATCH.
- MATCH (1 cycle, in_ready=0):
  - For every d in 1..SEARCH_LEN with S[d] valid, compute the run length of equal chars between the window position d back and L[0..].
  - Overlap into the look-ahead is allowed.
  - Invalid entries never match.
  - cap = min(LOOK_LEN-1, la_cnt-1).
  - Best = longest run clipped to cap. Ties go to the smallest d. No match gives offset=0, len=0.
  - Register offset=d-1, match_len=len, char_nxt=L[len] -> EMIT.
- EMIT:
  - out_valid=1. offset, match_len and char_nxt are stable while !out_ready.
  - On out_ready: out_valid=0 next cycle.
  - If char_nxt==END_CHAR -> DONE.
  - Else -> SHIFT with pend=match_len+1.
- DONE: finish=1, in_ready=0, out_valid=0, held until reset.
- Latency:
  - First token: out_valid rises 2 cycles after the LOOK_LEN-th accepted char, or after the END_CHAR if it arrives earlier (pend drains one cycle per bubble).
  - Subsequent tokens: pend+1 cycles after acceptance, with no input stalls.
- END_CHAR is never matched past: the cap guarantees char_nxt is the last valid look-ahead char at the latest.
- in_valid during EMIT/MATCH/DONE is ignored; no char is lost.

Test Plan:
- "abab$", out_ready=1 -> tokens (0,0,'a'), (0,0,'b'), (1,2,'$'); finish=1 the cycle after the third token is accepted; in_ready=0 thereafter.
- "aaaaaa$" -> (0,0,'a'), (0,5,'$'). Checks overlapping match at offset 0.
- "aXaYa$" -> (0,0,'a'), (0,0,'X'), (1,1,'Y'), (1,1,'$'). Checks tie-break to the smallest offset (d=2 over d=4).
- Twenty 'a' then '$', LOOK_LEN=8 -> (0,0,'a'), (0,7,'a'), (0,7,'a'), (0,3,'$'). Checks cap=LOOK_LEN-1 and the la_cnt cap at end of stream.
- "abab$" with out_ready low 5 cycles per token and in_valid toggling every other cycle -> identical tokens; outputs stable while stalled; no dropped or duplicated chars.
- Reset asserted mid-EMIT of the 2nd token, then "ab$" -> outputs 0 the cycle after reset; tokens (0,0,'a'), (0,0,'b'), (0,0,'$'); no match against pre-reset history.

Source files
------------

// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: accepts characters over valid/ready, keeps a sliding
// search + look-ahead window and emits (offset, match_len, char_nxt) tokens.
module lz77_stream_encoder #(
    parameter int unsigned       CHAR_W     = 8,
    parameter int unsigned       SEARCH_LEN = 9,
    parameter int unsigned       LOOK_LEN   = 8,
    parameter int unsigned       OFF_W      = 4,
    parameter int unsigned       LEN_W      = 3,
    parameter logic [CHAR_W-1:0] END_CHAR   = 8'h24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CHAR_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OFF_W-1:0]  offset_o,
    output logic [LEN_W-1:0]  match_len_o,
    output logic [CHAR_W-1:0] char_nxt_o,
    output logic              finish_o
);

    localparam int unsigned WinLen = SEARCH_LEN + LOOK_LEN;
    localparam logic [LEN_W:0] LenOne = 1;
    localparam logic [LEN_W:0] LookLenP = LOOK_LEN[LEN_W:0];

    typedef enum logic [1:0] {StShift, StMatch, StEmit, StDone} state_e;

    // Entry 0 is the oldest; entry WinLen-1 is the tail where new chars enter.
    // Search S[d] = entry SEARCH_LEN-d, look-ahead L[i] = entry SEARCH_LEN+i.
    logic [CHAR_W-1:0] win_data_q [WinLen];
    logic [WinLen-1:0] win_vld_q;
    state_e            state_q;
    logic [LEN_W:0]    pend_q;
    logic              ended_q;

    logic              take, fill;
    logic [LEN_W:0]    la_cnt, cap, run, best_len;
    logic [OFF_W-1:0]  best_off;
    logic              alive;

    assign in_ready_o = (state_q == StShift) && !ended_q;
    assign take       = (state_q == StShift) && in_valid_i && in_ready_o;
    // After the terminator, keep draining the window with invalid entries.
    assign fill       = (state_q == StShift) && !take && ended_q;

    // Longest-match search over every search distance, clipped to the look-ahead cap.
    always_comb begin
        la_cnt = '0;
        for (int i = 0; i < LOOK_LEN; i++) begin
            if (win_vld_q[SEARCH_LEN+i]) la_cnt = la_cnt + LenOne;
        end
        // Never match the last valid look-ahead char so char_nxt always exists.
        cap      = (la_cnt != '0) ? la_cnt - LenOne : '0;
        best_len = '0;
        best_off = '0;
        run      = '0;
        alive    = 1'b0;
        for (int d = 1; d <= SEARCH_LEN; d++) begin
            run   = '0;
            alive = win_vld_q[SEARCH_LEN-d];
            // Comparing position SEARCH_LEN+i-d lets the run overlap into the look-ahead.
            for (int i = 0; i < LOOK_LEN; i++) begin
                if (alive && win_vld_q[SEARCH_LEN+i-d] && win_vld_q[SEARCH_LEN+i] &&
                    (win_data_q[SEARCH_LEN+i-d] == win_data_q[SEARCH_LEN+i])) begin
                    run = run + LenOne;
                end else begin
                    alive = 1'b0;
                end
            end
            if (run > cap) run = cap;
            // Strict compare keeps the smallest distance on ties.
            if (run > best_len) begin
                best_len = run;
                best_off = OFF_W'(d - 1);
            end
        end
    end

    // Control FSM, window shift register and registered token outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StShift;
            pend_q      <= LookLenP;
            ended_q     <= 1'b0;
            win_vld_q   <= '0;
            out_valid_o <= 1'b0;
            offset_o    <= '0;
            match_len_o <= '0;
            char_nxt_o  <= '0;
            finish_o    <= 1'b0;
            for (int k = 0; k < WinLen; k++) win_data_q[k] <= '0;
        end else begin
            unique case (state_q)
                StShift: begin
                    if (take || fill) begin
                        for (int k = 0; k < WinLen - 1; k++) win_data_q[k] <= win_data_q[k+1];
                        win_data_q[WinLen-1] <= in_data_i;
                        win_vld_q            <= {take, win_vld_q[WinLen-1:1]};
                        if (take && (in_data_i == END_CHAR)) ended_q <= 1'b1;
                        pend_q <= pend_q - LenOne;
                        if (pend_q == LenOne) state_q <= StMatch;
                    end
                end
                StMatch: begin
                    offset_o    <= best_off;
                    match_len_o <= best_len[LEN_W-1:0];
                    char_nxt_o  <= win_data_q[SEARCH_LEN+int'(best_len)];
                    out_valid_o <= 1'b1;
                    state_q     <= StEmit;
                end
                StEmit: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (char_nxt_o == END_CHAR) begin
                            state_q  <= StDone;
                            finish_o <= 1'b1;
                        end else begin
                            state_q <= StShift;
                            pend_q  <= {1'b0, match_len_o} + LenOne;
                        end
                    end
                end
                StDone: begin
                end
                default: state_q <= StShift;
            endcase
        end
    end

endmodule
